// File: rtl/wb_pkg.sv
// Shared types and defaults for the single-master Wishbone slave multiplexer.
// The default map is the SOPC layout: RAM, flash, UART, segment display, peripheral catch-all.
package wb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ACTIVE    = 3'd1,
        ST_RESP      = 3'd2,
        ST_ERR       = 3'd3,
        ST_WAIT_DROP = 3'd4
    } wb_state_t;

    function automatic int WB_SEL_W(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int wb_idx_w(input int num_slaves);
        return (num_slaves > 1) ? $clog2(num_slaves) : 1;
    endfunction

    localparam int DEF_NUM_SLAVES = 5;

    // Slave 4 overlaps slaves 2/3 on purpose: the lower index takes priority.
    localparam logic [DEF_NUM_SLAVES*32-1:0] DEF_SLV_BASE = {
        32'h2000_0000, 32'h2000_0100, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000
    };
    localparam logic [DEF_NUM_SLAVES*32-1:0] DEF_SLV_MASK = {
        32'hE000_0000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFF00_0000, 32'hFFF0_0000
    };

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational priority address matcher: the lowest-index slave whose window
// contains the address wins; reports hit flag, one-hot select and binary index.
module wb_addr_decode
    import wb_pkg::*;
#(
    parameter int                             NUM_SLAVES = DEF_NUM_SLAVES,
    parameter int                             ADDR_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLV_BASE   = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLV_MASK   = '0,
    localparam int                            IDX_W      = wb_idx_w(NUM_SLAVES)
) (
    input  logic [ADDR_W-1:0]     i_adr,
    output logic                  o_hit,
    output logic [NUM_SLAVES-1:0] o_onehot,
    output logic [IDX_W-1:0]      o_idx
);

    logic [NUM_SLAVES-1:0] w_match;

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
            assign w_match[gi] =
                (i_adr & SLV_MASK[gi*ADDR_W +: ADDR_W]) == SLV_BASE[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // Scan from the top down so the lowest matching index is the last one written.
    always_comb begin
        o_hit    = |w_match;
        o_onehot = '0;
        o_idx    = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_idx       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_slave_mux.sv
// Single-master Wishbone interconnect: forwards one transaction at a time to the
// decoded slave, with unmapped/timeout error pulses, master abort and error counting.
module wb_slave_mux
    import wb_pkg::*;
#(
    parameter int                            NUM_SLAVES  = DEF_NUM_SLAVES,
    parameter int                            ADDR_W      = 32,
    parameter int                            DATA_W      = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_BASE    = DEF_SLV_BASE,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_MASK    = DEF_SLV_MASK,
    parameter int                            TIMEOUT_CYC = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_W-1:0]              m_adr_i,
    input  logic [DATA_W-1:0]              m_dat_i,
    input  logic [WB_SEL_W(DATA_W)-1:0]    m_sel_i,
    input  logic                           m_we_i,
    input  logic                           m_stb_i,
    input  logic                           m_cyc_i,
    output logic [DATA_W-1:0]              m_dat_o,
    output logic                           m_ack_o,
    output logic                           m_err_o,
    output logic [ADDR_W-1:0]              s_adr_o,
    output logic [DATA_W-1:0]              s_dat_o,
    output logic [WB_SEL_W(DATA_W)-1:0]    s_sel_o,
    output logic                           s_we_o,
    output logic [NUM_SLAVES-1:0]          s_cyc_o,
    output logic [NUM_SLAVES-1:0]          s_stb_o,
    input  logic [NUM_SLAVES*DATA_W-1:0]   s_dat_i,
    input  logic [NUM_SLAVES-1:0]          s_ack_i,
    output logic                           busy_o,
    output logic [7:0]                     err_cnt_o
);

    localparam int SEL_W = WB_SEL_W(DATA_W);
    localparam int IDX_W = wb_idx_w(NUM_SLAVES);
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    wb_state_t             r_state;
    logic [DATA_W-1:0]     r_m_dat;
    logic                  r_m_ack;
    logic                  r_m_err;
    logic [ADDR_W-1:0]     r_s_adr;
    logic [DATA_W-1:0]     r_s_dat;
    logic [SEL_W-1:0]      r_s_sel;
    logic                  r_s_we;
    logic [NUM_SLAVES-1:0] r_s_cyc;
    logic [NUM_SLAVES-1:0] r_s_stb;
    logic                  r_busy;
    logic [7:0]            r_err_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_tcnt;

    logic                  w_hit;
    logic [NUM_SLAVES-1:0] w_onehot;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_sel_ack;
    logic [DATA_W-1:0]     w_sel_dat;
    logic [7:0]            w_err_cnt_inc;

    wb_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_decode (
        .i_adr    (m_adr_i),
        .o_hit    (w_hit),
        .o_onehot (w_onehot),
        .o_idx    (w_idx)
    );

    assign w_sel_ack     = s_ack_i[r_idx];
    assign w_sel_dat     = s_dat_i[r_idx*DATA_W +: DATA_W];
    assign w_err_cnt_inc = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_m_dat   <= '0;
            r_m_ack   <= 1'b0;
            r_m_err   <= 1'b0;
            r_s_adr   <= '0;
            r_s_dat   <= '0;
            r_s_sel   <= '0;
            r_s_we    <= 1'b0;
            r_s_cyc   <= '0;
            r_s_stb   <= '0;
            r_busy    <= 1'b0;
            r_err_cnt <= '0;
            r_idx     <= '0;
            r_tcnt    <= '0;
        end else begin
            r_m_ack <= 1'b0;
            r_m_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (m_cyc_i && m_stb_i) begin
                        r_s_adr <= m_adr_i;
                        r_s_dat <= m_dat_i;
                        r_s_sel <= m_sel_i;
                        r_s_we  <= m_we_i;
                        r_idx   <= w_idx;
                        r_tcnt  <= '0;
                        r_busy  <= 1'b1;
                        if (w_hit) begin
                            r_s_cyc <= w_onehot;
                            r_s_stb <= w_onehot;
                            r_state <= ST_ACTIVE;
                        end else begin
                            r_m_err   <= 1'b1;
                            r_err_cnt <= w_err_cnt_inc;
                            r_state   <= ST_ERR;
                        end
                    end
                end
                ST_ACTIVE: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    // Abort beats everything; a late ack wins over a same-cycle timeout.
                    if (!m_cyc_i) begin
                        r_s_cyc <= '0;
                        r_s_stb <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_sel_ack) begin
                        r_s_cyc <= '0;
                        r_s_stb <= '0;
                        r_m_ack <= 1'b1;
                        if (!r_s_we) begin
                            r_m_dat <= w_sel_dat;
                        end
                        r_state <= ST_RESP;
                    end else if (r_tcnt == TIMEOUT_LAST) begin
                        r_s_cyc   <= '0;
                        r_s_stb   <= '0;
                        r_m_err   <= 1'b1;
                        r_err_cnt <= w_err_cnt_inc;
                        r_state   <= ST_ERR;
                    end
                end
                ST_RESP, ST_ERR: begin
                    r_state <= ST_WAIT_DROP;
                end
                ST_WAIT_DROP: begin
                    if (!m_stb_i) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_dat_o   = r_m_dat;
    assign m_ack_o   = r_m_ack;
    assign m_err_o   = r_m_err;
    assign s_adr_o   = r_s_adr;
    assign s_dat_o   = r_s_dat;
    assign s_sel_o   = r_s_sel;
    assign s_we_o    = r_s_we;
    assign s_cyc_o   = r_s_cyc;
    assign s_stb_o   = r_s_stb;
    assign busy_o    = r_busy;
    assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_wb_slave_mux.sv
// Randomized scoreboard bench for wb_slave_mux: a reference model predicts each
// transaction's response; a monitor pops predictions whenever ack/err appears.
module tb_wb_slave_mux;
    import wb_pkg::*;

    localparam int NS = 5;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    localparam logic [31:0] B0 = 32'h0000_0000, M0 = 32'hFFF0_0000;
    localparam logic [31:0] B1 = 32'h1000_0000, M1 = 32'hFF00_0000;
    localparam logic [31:0] B2 = 32'h2000_0000, M2 = 32'hFFFF_FF00;
    localparam logic [31:0] B3 = 32'h2000_0100, M3 = 32'hFFFF_FF00;
    localparam logic [31:0] B4 = 32'h2000_0000, M4 = 32'hE000_0000;
    localparam logic [NS*AW-1:0] P_BASE = {B4, B3, B2, B1, B0};
    localparam logic [NS*AW-1:0] P_MASK = {M4, M3, M2, M1, M0};

    logic              clk, rst;
    logic [AW-1:0]     m_adr_i;
    logic [DW-1:0]     m_dat_i;
    logic [3:0]        m_sel_i;
    logic              m_we_i, m_stb_i, m_cyc_i;
    logic [DW-1:0]     m_dat_o;
    logic              m_ack_o, m_err_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [3:0]        s_sel_o;
    logic              s_we_o;
    logic [NS-1:0]     s_cyc_o, s_stb_o;
    logic [NS*DW-1:0]  s_dat_i;
    logic [NS-1:0]     s_ack_i;
    logic              busy_o;
    logic [7:0]        err_cnt_o;

    wb_slave_mux #(
        .NUM_SLAVES (NS), .ADDR_W (AW), .DATA_W (DW),
        .SLV_BASE (P_BASE), .SLV_MASK (P_MASK), .TIMEOUT_CYC (TO)
    ) dut (
        .clk (clk), .rst (rst),
        .m_adr_i (m_adr_i), .m_dat_i (m_dat_i), .m_sel_i (m_sel_i), .m_we_i (m_we_i),
        .m_stb_i (m_stb_i), .m_cyc_i (m_cyc_i),
        .m_dat_o (m_dat_o), .m_ack_o (m_ack_o), .m_err_o (m_err_o),
        .s_adr_o (s_adr_o), .s_dat_o (s_dat_o), .s_sel_o (s_sel_o), .s_we_o (s_we_o),
        .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o), .s_dat_i (s_dat_i), .s_ack_i (s_ack_i),
        .busy_o (busy_o), .err_cnt_o (err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [31:0] dat;
        logic [7:0]  cnt;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc_num  = 0;
    int          stb_events = 0;
    int          cur_lat  = 100;
    logic [31:0] cur_rdata = '0;
    int          exp_slv  = -1;
    logic [NS-1:0] exp_onehot = '0;
    logic [31:0] exp_adr = '0, exp_wdat = '0;
    logic        exp_we = 1'b0;
    logic [31:0] last_rd = '0;
    int          err_model = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] base_of(input int i);
        case (i)
            0: return B0; 1: return B1; 2: return B2; 3: return B3; default: return B4;
        endcase
    endfunction

    function automatic logic [31:0] mask_of(input int i);
        case (i)
            0: return M0; 1: return M1; 2: return M2; 3: return M3; default: return M4;
        endcase
    endfunction

    // Window rule: first slave (lowest index) whose masked address equals its base.
    function automatic int ref_decode(input logic [31:0] adr);
        for (int i = 0; i < NS; i++)
            if ((adr & mask_of(i)) == base_of(i)) return i;
        return -1;
    endfunction

    always @(posedge clk) cyc_num <= cyc_num + 1;

    // Slave model: selected slave acks in its cur_lat-th strobe cycle; others spray junk acks.
    int scnt = 0;
    always @(negedge clk) begin
        logic [NS-1:0] ack;
        if (s_stb_o != '0) scnt++;
        else scnt = 0;
        ack = NS'($urandom) & ~s_stb_o;
        if (s_stb_o != '0 && scnt == cur_lat) ack = ack | s_stb_o;
        s_ack_i = ack;
        for (int i = 0; i < NS; i++)
            s_dat_i[i*DW +: DW] = (i == exp_slv) ? cur_rdata : $urandom;
    end

    // Monitor / scoreboard.
    logic [NS-1:0] prev_stb = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (s_stb_o != '0 && prev_stb == '0) stb_events++;
            if (s_stb_o != '0) begin
                check("s_stb_select", s_stb_o, exp_onehot);
                check("s_cyc_select", s_cyc_o, exp_onehot);
                check("s_adr", s_adr_o, exp_adr);
                check("s_we", s_we_o, exp_we);
                check("s_dat", s_dat_o, exp_wdat);
            end
            if (m_ack_o || m_err_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got ack=%0b err=%0b, required none", m_ack_o, m_err_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_kind", {m_ack_o, m_err_o}, e.is_err ? 2'b01 : 2'b10);
                    check("resp_cycle", cyc_num, e.cyc);
                    check("err_cnt", err_cnt_o, e.cnt);
                    if (!e.is_err) check("rd_data", m_dat_o, e.dat);
                end
            end
            prev_stb = s_stb_o;
        end else begin
            prev_stb = '0;
        end
    end

    task automatic idle_master();
        m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
        m_adr_i = '0;   m_dat_i = '0;   m_sel_i = '0;
    endtask

    task automatic run_txn(input logic [31:0] adr, input bit we, input logic [31:0] wdat,
                           input logic [31:0] rdat, input int lat, input int abort_at,
                           input int hold, input string tag);
        int slv, start, base_ev, w;
        exp_t e;
        slv = ref_decode(adr);
        cur_lat = lat; cur_rdata = rdat; exp_slv = slv;
        exp_onehot = (slv >= 0) ? NS'(1 << slv) : '0;
        exp_adr = adr; exp_we = we; exp_wdat = wdat;
        @(posedge clk); #1;
        start = cyc_num;
        base_ev = stb_events;
        e.is_err = 1'b0; e.dat = '0; e.cyc = 0;
        if (slv < 0) begin
            if (err_model < 255) err_model++;
            e.is_err = 1'b1; e.cyc = start + 1;
        end else if (abort_at == 0) begin
            if (lat <= TO) begin
                if (!we) last_rd = rdat;
                e.dat = last_rd; e.cyc = start + lat + 1;
            end else begin
                if (err_model < 255) err_model++;
                e.is_err = 1'b1; e.cyc = start + TO + 1;
            end
        end
        e.cnt = 8'(err_model);
        if (slv < 0 || abort_at == 0) exp_q.push_back(e);
        m_adr_i = adr; m_we_i = we; m_dat_i = wdat; m_sel_i = 4'($urandom);
        m_cyc_i = 1'b1; m_stb_i = 1'b1;
        if (abort_at > 0 && slv >= 0) begin
            repeat (abort_at) @(posedge clk);
            #1 idle_master();
            @(posedge clk); @(negedge clk);
            check({tag, "_abort_stb"}, {s_cyc_o, s_stb_o}, '0);
            check({tag, "_abort_busy"}, busy_o, 1'b0);
            repeat (3) @(negedge clk);
        end else begin
            w = 0;
            while (exp_q.size() != 0 && w < 40) begin
                @(negedge clk);
                w++;
            end
            if (exp_q.size() != 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_timeout: got no response in 40 cycles, required ack/err", tag);
                exp_q.delete();
            end
            check({tag, "_busy_hold"}, busy_o, 1'b1);
            repeat (hold) @(posedge clk);
            @(posedge clk); #1 idle_master();
            @(posedge clk); @(negedge clk);
        end
        check({tag, "_idle_busy"}, busy_o, 1'b0);
        check({tag, "_stb_issues"}, stb_events - base_ev, (slv >= 0) ? 1 : 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_side"}, {m_dat_o, m_ack_o, m_err_o, busy_o, err_cnt_o}, '0);
        check({tag, "_s_ctrl"}, {s_adr_o, s_we_o, s_sel_o}, '0);
        check({tag, "_s_dat"}, s_dat_o, '0);
        check({tag, "_s_strb"}, {s_cyc_o, s_stb_o}, '0);
    endtask

    function automatic logic [31:0] rand_adr();
        int r;
        r = $urandom_range(0, 6);
        if (r < NS) return base_of(r) | ($urandom & ~mask_of(r));
        if (r == 5) return 32'h4000_0000 | ($urandom & 32'h3FFF_FFFF);
        return $urandom;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_master();
        s_ack_i = '0; s_dat_i = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_all_zero("init_rst");
        @(negedge clk) rst = 1'b0;

        run_txn(32'h0000_0010, 1'b0, 32'h0, 32'hDEAD_BEEF, 3, 0, 0, "read_s0");
        run_txn(32'hF000_0000, 1'b1, 32'h1234_5678, 32'h0, 1, 0, 0, "unmapped");
        check("unmapped_cnt", err_cnt_o, 8'd1);
        run_txn(32'h1000_0040, 1'b0, 32'h0, 32'hCAFE_0001, 5, 0, 0, "timeout");
        run_txn(32'h1000_0044, 1'b0, 32'h0, 32'hCAFE_0002, 4, 0, 0, "ack_at_limit");
        run_txn(32'h2000_0004, 1'b1, 32'hAAAA_5555, 32'h0, 100, 2, 0, "abort");
        run_txn(32'h2000_0108, 1'b0, 32'h0, 32'h0BAD_F00D, 2, 0, 5, "held_stb");
        run_txn(32'h3000_0000, 1'b1, 32'h7777_0000, 32'h0, 1, 0, 0, "write_s4");

        // Asynchronous reset in the middle of an active transfer.
        cur_lat = 100; exp_slv = 1; exp_onehot = NS'(2);
        exp_adr = 32'h1000_0000; exp_we = 1'b0; exp_wdat = '0;
        @(posedge clk); #1;
        m_adr_i = 32'h1000_0000; m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_dat_i = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("mid_rst");
        idle_master();
        exp_q.delete();
        last_rd = '0; err_model = 0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check("post_rst_busy", busy_o, 1'b0);

        for (int n = 0; n < 150; n++) begin
            int lat, ab;
            lat = $urandom_range(1, 6);
            ab  = 0;
            if ($urandom_range(0, 7) == 0) begin
                ab = $urandom_range(1, 3);
                lat = 100;
            end
            run_txn(rand_adr(), 1'($urandom), $urandom, $urandom, lat, ab,
                    $urandom_range(0, 5), "rand");
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        for (int n = 0; n < 300; n++)
            run_txn(32'hF000_0000 | 32'($urandom_range(0, 255)), 1'b0, 32'h0, 32'h0, 1, 0, 0, "err_sat");
        check("err_cnt_saturated", err_cnt_o, 8'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
